// File: rtl/sum_seg_display.sv
// Captures the 5-bit adder result and shows it as two multiplexed decimal digits on a 7-segment display.
// Latency: value_q updates on the load edge; seg/an follow one edge later.
// Backpressure: none. load is a plain strobe and is sampled on every edge.
module sum_seg_display #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] sum_in,
  input  logic       cout_in,
  output logic [4:0] value_q,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);

  localparam logic [19:0] TC       = 20'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]  AN_OFF   = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [1:0]  AN_UNITS = SEG_ACTIVE_LOW ? 2'b10 : 2'b01;
  localparam logic [1:0]  AN_TENS  = SEG_ACTIVE_LOW ? 2'b01 : 2'b10;
  localparam logic        DP_OFF   = SEG_ACTIVE_LOW;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t      state;
  logic [19:0] cnt;
  logic        digit_sel;
  logic [1:0]  tens;
  logic [3:0]  units;

  function automatic logic [6:0] pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  // Value never exceeds 31, so a three-way compare replaces a divider.
  always_comb begin
    tens = 2'd0;
    if (value_q >= 5'd30)      tens = 2'd3;
    else if (value_q >= 5'd20) tens = 2'd2;
    else if (value_q >= 5'd10) tens = 2'd1;
    units = 4'(value_q - 5'(tens) * 5'd10);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q   <= '0;
      cnt       <= '0;
      digit_sel <= 1'b0;
      state     <= IDLE;
      seg       <= SEG_OFF;
      an        <= AN_OFF;
      dp        <= DP_OFF;
    end else begin
      if (cnt == TC) begin
        cnt       <= '0;
        digit_sel <= ~digit_sel;
      end else begin
        cnt <= cnt + 20'd1;
      end

      if (load) value_q <= {cout_in, sum_in};
      dp <= DP_OFF;

      case (state)
        IDLE: begin
          seg <= SEG_OFF;
          an  <= AN_OFF;
          if (load) state <= SHOW;
        end
        SHOW: begin
          if (!digit_sel) begin
            seg <= pattern(units);
            an  <= AN_UNITS;
          end else if (tens != 2'd0) begin
            seg <= pattern({2'b00, tens});
            an  <= AN_TENS;
          end else begin
            // Leading zero: tens digit dark for this whole phase.
            seg <= SEG_OFF;
            an  <= AN_OFF;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_seg_display.sv
// Bench for sum_seg_display: vector table, hand-written corner sequences and a random run against an arithmetic model.
module tb_sum_seg_display;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] sum_in = '0;
  logic       cout_in = 1'b0;
  logic [4:0] value_q;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;

  sum_seg_display #(.REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .sum_in(sum_in), .cout_in(cout_in),
    .value_q(value_q), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: shown flag, last loaded value, and edges seen since reset release.
  bit         m_shown;
  int         m_val;
  int         m_edges;
  logic [6:0] pat [10];

  typedef struct {
    logic [4:0] val;
    logic [6:0] tens_seg;
    logic [1:0] tens_an;
    logic [6:0] units_seg;
  } vec_t;
  vec_t vecs [7];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_out(output logic [6:0] es, output logic [1:0] ea);
    int t, u;
    es = 7'h7F;
    ea = 2'b11;
    if (m_shown) begin
      t = m_val / 10;
      u = m_val % 10;
      if (((m_edges / RD) % 2) == 0) begin
        es = ~pat[u];
        ea = 2'b10;
      end else if (t != 0) begin
        es = ~pat[t];
        ea = 2'b01;
      end
    end
  endfunction

  // One clock: drive inputs now (away from the edge), then check #1 after the edge.
  task automatic step(input logic ld, input logic [4:0] v, input string name);
    logic [6:0] es;
    logic [1:0] ea;
    load = ld;
    {cout_in, sum_in} = v;
    model_out(es, ea);
    if (ld) begin
      m_val   = int'(v);
      m_shown = 1'b1;
    end
    @(posedge clk);
    #1;
    m_edges++;
    cmp(name, {17'd0, value_q, seg, an, dp}, {17'd0, 5'(m_val), es, ea, 1'b1});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_state", {17'd0, value_q, seg, an, dp}, {17'd0, 5'd0, 7'h7F, 2'b11, 1'b1});
    rst_n   = 1'b1;
    m_shown = 1'b0;
    m_val   = 0;
    m_edges = 0;
  endtask

  initial begin
    logic [6:0] seen_u, seen_t;
    logic [1:0] seen_ta;
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    vecs[0] = '{5'd30, 7'h30, 2'b01, 7'h40};
    vecs[1] = '{5'd5,  7'h7F, 2'b11, 7'h12};
    vecs[2] = '{5'd31, 7'h30, 2'b01, 7'h79};
    vecs[3] = '{5'd10, 7'h79, 2'b01, 7'h40};
    vecs[4] = '{5'd9,  7'h7F, 2'b11, 7'h10};
    vecs[5] = '{5'd0,  7'h7F, 2'b11, 7'h40};
    vecs[6] = '{5'd21, 7'h24, 2'b01, 7'h79};

    // Reset and idle: blank for 20 cycles with no load.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 5'd0, "idle_blank");

    // Vector table: each value must show both of its phases correctly.
    for (int k = 0; k < 7; k++) begin
      step(1'b1, vecs[k].val, "table_load");
      seen_u  = 7'h00;
      seen_t  = 7'h00;
      seen_ta = 2'b00;
      for (int i = 0; i < 9; i++) begin
        step(1'b0, 5'd0, "table_run");
        if (an == 2'b10) seen_u = seg;
        else begin
          seen_t  = seg;
          seen_ta = an;
        end
      end
      cmp($sformatf("units_seg_%0d", vecs[k].val), {25'd0, seen_u}, {25'd0, vecs[k].units_seg});
      cmp($sformatf("tens_seg_%0d", vecs[k].val), {25'd0, seen_t}, {25'd0, vecs[k].tens_seg});
      cmp($sformatf("tens_an_%0d", vecs[k].val), {30'd0, seen_ta}, {30'd0, vecs[k].tens_an});
    end

    // Load on terminal count: new value and new digit appear together next cycle.
    do_reset();
    repeat (3) step(1'b0, 5'd0, "tc_pre");
    step(1'b1, 5'd21, "tc_load");
    step(1'b0, 5'd0, "tc_next");
    cmp("tc_seg_hand", {25'd0, seg}, {25'd0, 7'h24});
    cmp("tc_an_hand", {30'd0, an}, {30'd0, 2'b01});

    // Held load: the last sampled value wins.
    step(1'b1, 5'd7, "hold_a");
    step(1'b1, 5'd18, "hold_b");
    step(1'b0, 5'd0, "hold_c");
    cmp("hold_value", {27'd0, value_q}, {27'd0, 5'd18});

    // Async reset mid-display, then stay blank until the next load.
    step(1'b1, 5'd30, "mid_load");
    repeat (3) step(1'b0, 5'd0, "mid_show");
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_blank", {22'd0, value_q, seg, an, dp}, {22'd0, 5'd0, 7'h7F, 2'b11, 1'b1});
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 5'd0, "post_reset_blank");

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
